// File: rtl/sender_arbiter.sv
// Three-way arbiter in front of the single 40-bit serial frame sender: accepts one frame,
// holds it on out_data for VALID_CYCLES, then waits HOLDOFF cycles. Macro SENDER_ARBITER_ROUND_ROBIN_EN.
module sender_arbiter #(
  parameter int DATA_WIDTH   = 40,
  parameter int VALID_CYCLES = 2,
  parameter int HOLDOFF      = 64
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req2_data,
  input  logic                  req2_valid,
  output logic                  req2_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic [1:0]            last_grant,
  output logic [1:0]            state_dbg
);

  // Handshake: a requester transfers at a clk edge where reqN_valid & reqN_ready are both high;
  // it must hold data and valid until then, and ready is only ever high in IDLE.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam int MAX_CNT = (VALID_CYCLES > HOLDOFF) ? VALID_CYCLES : HOLDOFF;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [CW-1:0] VC_LAST = CW'(VALID_CYCLES - 1);
  localparam logic [CW-1:0] HO_LAST = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

`ifdef SENDER_ARBITER_ROUND_ROBIN_EN
  localparam logic [1:0] LAST_GRANT_RST = 2'd2;
`else
  localparam logic [1:0] LAST_GRANT_RST = 2'd0;
`endif

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]            last_grant_q, last_grant_d;

  logic [2:0]            v;
  logic                  gnt_any;
  logic [1:0]            gnt_idx;
  logic [DATA_WIDTH-1:0] gnt_data;

  assign v       = {req2_valid, req1_valid, req0_valid};
  assign gnt_any = |v;

  always_comb begin
    gnt_idx = 2'd0;
`ifdef SENDER_ARBITER_ROUND_ROBIN_EN
    // Search begins just after the previous winner and wraps modulo 3.
    case (last_grant_q)
      2'd0:    if (v[1]) gnt_idx = 2'd1; else if (v[2]) gnt_idx = 2'd2; else gnt_idx = 2'd0;
      2'd1:    if (v[2]) gnt_idx = 2'd2; else if (v[0]) gnt_idx = 2'd0; else gnt_idx = 2'd1;
      default: if (v[0]) gnt_idx = 2'd0; else if (v[1]) gnt_idx = 2'd1; else gnt_idx = 2'd2;
    endcase
`else
    if (v[0])      gnt_idx = 2'd0;
    else if (v[1]) gnt_idx = 2'd1;
    else           gnt_idx = 2'd2;
`endif
  end

  always_comb begin
    case (gnt_idx)
      2'd0:    gnt_data = req0_data;
      2'd1:    gnt_data = req1_data;
      default: gnt_data = req2_data;
    endcase
  end

  logic grant_open;
  // Gated by n_reset so no requester sees ready while reset is held.
  assign grant_open = n_reset & (state_q == ST_IDLE) & gnt_any;
  assign req0_ready = grant_open & (gnt_idx == 2'd0);
  assign req1_ready = grant_open & (gnt_idx == 2'd1);
  assign req2_ready = grant_open & (gnt_idx == 2'd2);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any) begin
          out_data_d   = gnt_data;
          last_grant_d = gnt_idx;
          cnt_d        = '0;
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cnt_q == VC_LAST) begin
          cnt_d   = '0;
          // With no hold-off the next grant can follow immediately.
          state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == HO_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      out_data_q   <= '0;
      last_grant_q <= LAST_GRANT_RST;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = (state_q == ST_ISSUE);
  assign busy       = (state_q != ST_IDLE);
  assign last_grant = last_grant_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sender_arbiter.sv
// Bench for sender_arbiter (default build): directed frames, expected {grant, data} queued
// at issue time and popped by a monitor whenever out_valid rises.
module tb_sender_arbiter;

  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          n_reset;
  logic [DW-1:0] req0_data, req1_data, req2_data;
  logic          req0_valid, req1_valid, req2_valid;
  logic          req0_ready, req1_ready, req2_ready;
  logic [DW-1:0] out_data;
  logic          out_valid, busy;
  logic [1:0]    last_grant, state_dbg;

  sender_arbiter #(.DATA_WIDTH(DW), .VALID_CYCLES(2), .HOLDOFF(64)) dut (
    .clk(clk), .n_reset(n_reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req2_data(req2_data), .req2_valid(req2_valid), .req2_ready(req2_ready),
    .out_data(out_data), .out_valid(out_valid), .busy(busy),
    .last_grant(last_grant), .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard
  logic [DW+1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  logic prev_valid = 1'b0;
  int   vrun = 0;
  always @(negedge clk) begin
    logic [DW+1:0] e;
    if (!n_reset) begin
      prev_valid = 1'b0;
      vrun = 0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'(out_data), 64'h0);
          n_bad += (out_data == '0) ? 1 : 0;
        end else begin
          e = exp_q.pop_front();
          check("frame_data", 64'(out_data), 64'(e[DW-1:0]));
          check("frame_grant", 64'(last_grant), 64'(e[DW+1:DW]));
        end
      end
      if (out_valid) vrun++;
      if (!out_valid && prev_valid) begin
        check("valid_len", 64'(vrun), 64'd2);
        vrun = 0;
      end
      if (busy) check("ready_while_busy", 64'({req2_ready, req1_ready, req0_ready}), 64'h0);
      prev_valid = out_valid;
    end
  end

  // Driver tasks
  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(name, 64'(busy), 64'h0);
  endtask

  task automatic send0(input logic [DW-1:0] d);
    @(posedge clk); #1;
    req0_data = d; req0_valid = 1'b1;
    exp_q.push_back({2'd0, d});
    @(negedge clk);
    check("req0_ready", 64'(req0_ready), 64'h1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    int starts[$];
    logic [2:0] r;
    int n;
    n_reset = 1'b0;
    req0_data = '0; req1_data = '0; req2_data = '0;
    req0_valid = 1'b0; req1_valid = 1'b0; req2_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", 64'(out_data), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_last_grant", 64'(last_grant), 64'h0);
    check("rst_state", 64'(state_dbg), 64'h0);
    check("rst_ready", 64'({req2_ready, req1_ready, req0_ready}), 64'h0);
    req0_valid = 1'b0;
    @(posedge clk); #1 n_reset = 1'b1;

    // Single request on requester 1
    @(posedge clk); #1;
    req1_data = 40'hD999999991; req1_valid = 1'b1;
    exp_q.push_back({2'd1, 40'hD999999991});
    @(negedge clk);
    check("single_ready", 64'({req2_ready, req1_ready, req0_ready}), 64'h2);
    @(posedge clk); #1 req1_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 64'(n), 64'd66);
    check("single_last_grant", 64'(last_grant), 64'h1);
    check("single_state", 64'(state_dbg), 64'h0);

    // Contention: all three valid, fixed priority 0 > 1 > 2
    @(posedge clk); #1;
    req0_data = 40'h1; req1_data = 40'h2; req2_data = 40'h3;
    req0_valid = 1'b1; req1_valid = 1'b1; req2_valid = 1'b1;
    exp_q.push_back({2'd0, 40'h1});
    exp_q.push_back({2'd1, 40'h2});
    exp_q.push_back({2'd2, 40'h3});
    for (int c = 0; c < 400 && (req0_valid | req1_valid | req2_valid); c++) begin
      @(negedge clk);
      r = {req2_ready, req1_ready, req0_ready};
      if (r != 3'b000) starts.push_back(cyc);
      @(posedge clk); #1;
      if (r[0]) req0_valid = 1'b0;
      if (r[1]) req1_valid = 1'b0;
      if (r[2]) req2_valid = 1'b0;
    end
    check("contention_drained", 64'({req2_valid, req1_valid, req0_valid}), 64'h0);
    check("contention_grants", 64'(starts.size()), 64'd3);
    if (starts.size() == 3) begin
      check("spacing_0_1", 64'(starts[1] - starts[0]), 64'd67);
      check("spacing_1_2", 64'(starts[2] - starts[1]), 64'd67);
    end
    wait_idle("contention_idle");

    // Withdrawal: req2 pulsed during HOLD after a req0 frame
    send0(40'hA5A5A5A5A5);
    repeat (10) @(posedge clk);
    #1 req2_data = 40'hBEEF; req2_valid = 1'b1;
    @(negedge clk);
    check("withdraw_ready", 64'(req2_ready), 64'h0);
    @(posedge clk); #1 req2_valid = 1'b0;
    wait_idle("withdraw_idle");
    repeat (5) begin
      @(negedge clk);
      check("withdraw_no_frame", 64'(out_valid), 64'h0);
    end
    check("withdraw_last_grant", 64'(last_grant), 64'h0);

    // Reset one cycle after a transfer
    send0(40'h1234567890);
    @(posedge clk); #1 n_reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'h0);
    check("midrst_busy", 64'(busy), 64'h0);
    check("midrst_state", 64'(state_dbg), 64'h0);
    req0_data = 40'h0F0F0F0F0F; req0_valid = 1'b1;
    @(posedge clk); #1 n_reset = 1'b1;
    exp_q.push_back({2'd0, 40'h0F0F0F0F0F});
    @(negedge clk);
    check("post_reset_accept", 64'(req0_ready), 64'h1);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_idle("final_idle");

    // Final report
    check("exp_q_empty", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
